// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM stream reader and its FIFO.
// The reader's abort input exists only when BRAM_STREAM_ABORT_EN is defined.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int FIFO_DEPTH = 2;

  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry data+last FIFO with push/pop/flush and an occupancy count.
// Simultaneous push and pop are allowed; flush has priority over push.
module stream_fifo2
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic                  valid,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic                  last_q [FIFO_DEPTH];
  logic                  rd_ptr;
  logic                  wr_ptr;

  assign head_data = data_q[rd_ptr];
  assign head_last = last_q[rd_ptr];
  assign valid     = (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader for a 1-cycle-latency BRAM port, re-timed into a valid/ready stream.
// Define BRAM_STREAM_ABORT_EN to add an abort input that truncates a burst.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  b_en,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef BRAM_STREAM_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int CW = cnt_width(ADDR_WIDTH);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issued;
  logic                  inflight;
  logic                  inflight_last;
  logic                  pop;
  logic                  kill;
  logic                  issue_last;
  logic                  head_last;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;

`ifdef BRAM_STREAM_ABORT_EN
  assign kill = abort & ((state == RUN) | (state == DRAIN));
`else
  assign kill = 1'b0;
`endif

  assign pop        = m_valid & m_ready;
  // Words owed to the FIFO after this cycle's pop, counting the one in flight.
  assign occ        = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue_last = (issued == len_q - CW'(1));
  assign b_addr     = base_q + issued[ADDR_WIDTH-1:0];
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign m_last     = m_valid & head_last;

  always_comb begin
    state_nxt = state;
    b_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (kill) begin
          state_nxt = DONE;
        end else if (occ < 3'd2) begin
          b_en = 1'b1;
          if (issue_last) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (kill || occ == 3'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        len_q  <= length;
        issued <= '0;
      end else if (b_en) begin
        issued <= issued + CW'(1);
      end
      inflight      <= b_en;
      inflight_last <= b_en & issue_last;
    end
  end

  stream_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (kill),
    .push     (inflight),
    .push_data(b_dout),
    .push_last(inflight_last),
    .pop      (pop),
    .head_data(m_data),
    .head_last(head_last),
    .valid    (m_valid),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader with a behavioural BRAM.
// Covers bursts, wrap, backpressure, zero length, reset and optional abort.
module tb_bram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam logic [5:0] TOG = 6'b101001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
  logic          b_en;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef BRAM_STREAM_ABORT_EN
  logic          abort = 1'b0;
`endif

  always #5 clk = ~clk;

  bram_stream_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .b_en     (b_en),
    .b_addr   (b_addr),
    .b_dout   (b_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
`ifdef BRAM_STREAM_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  logic [DW-1:0] mem [2**AW];

  always @(posedge clk) begin
    if (b_en) b_dout <= mem[b_addr];
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            pat;
    int            exp_done;
    int            exp_first;
  } vec_t;

  int      n_chk = 0;
  int      n_fail = 0;
  beat_t   exp_q[$];
  logic [AW-1:0] addr_q[$];
  beat_t   e;
  bit      mon_on = 0;
  int      cyc, beats, en_cnt, done_cnt, last_cnt, max_buf, first_valid, done_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (b_en) begin
        en_cnt++;
        chk("addr_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) chk("b_addr", b_addr, addr_q.pop_front());
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        beats++;
        if (m_last) last_cnt++;
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.l);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (en_cnt - beats > max_buf) max_buf = en_cnt - beats;
    end
  end

  function automatic logic rdy(input int pat, input int i);
    if (pat == 0) return 1'b1;
    if (pat == 1) return TOG[i % 6];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < int'(l); k++) begin
      exp_q.push_back('{d: mem[AW'(int'(b) + k)], l: (k == int'(l) - 1)});
      addr_q.push_back(AW'(int'(b) + k));
    end
    beats = 0; en_cnt = 0; done_cnt = 0; last_cnt = 0;
    max_buf = 0; first_valid = -1; done_cyc = -1;
    @(posedge clk); #1;
    base_addr = b;
    length = l;
    start = 1'b1;
    m_ready = 1'b1;
    cyc = -1;
    mon_on = 1;
  endtask

  task automatic wait_done(input int pat, input int budget);
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      m_ready = rdy(pat, i - 1);
      @(negedge clk); #2;
      if (done_cnt > 0) break;
    end
  endtask

  task automatic run_vec(input vec_t v);
    start_burst(v.base, v.len);
    wait_done(v.pat, 200);
    repeat (3) @(negedge clk);
    #2;
    mon_on = 0;
    chk("done_pulses", done_cnt, 1);
    chk("beats", beats, v.len);
    chk("reads", en_cnt, v.len);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    chk("max_buffered_le2", max_buf <= 2, 1);
    chk("first_valid_cycle", first_valid, v.exp_first);
    chk("last_count", last_cnt, (v.len != 0) ? 1 : 0);
    chk("busy_after", busy, 0);
    if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i + 16);

    vecs.push_back('{base: 6'd4,  len: 7'd5,  pat: 0, exp_done: 8,  exp_first: 3});
    vecs.push_back('{base: 6'd62, len: 7'd4,  pat: 0, exp_done: 7,  exp_first: 3});
    vecs.push_back('{base: 6'd0,  len: 7'd0,  pat: 0, exp_done: 1,  exp_first: -1});
    vecs.push_back('{base: 6'd33, len: 7'd1,  pat: 0, exp_done: 4,  exp_first: 3});
    vecs.push_back('{base: 6'd10, len: 7'd5,  pat: 1, exp_done: -1, exp_first: 3});
    vecs.push_back('{base: 6'd0,  len: 7'd64, pat: 0, exp_done: 67, exp_first: 3});
    vecs.push_back('{base: 6'd60, len: 7'd9,  pat: 2, exp_done: -1, exp_first: 3});

    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, b_en, b_addr, m_valid, m_data, m_last}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset after two delivered beats, then a clean burst.
    start_burst(6'd8, 7'd6);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #2;
      if (beats >= 2) break;
    end
    chk("reset_pre_beats", beats, 2);
    mon_on = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_async_outputs", {busy, done, b_en, b_addr, m_valid, m_data, m_last}, '0);
    @(posedge clk); #1;
    chk("reset_no_done", {done, busy, m_valid}, '0);
    rst_n = 1'b1;
    run_vec('{base: 6'd20, len: 7'd3, pat: 0, exp_done: 6, exp_first: 3});

`ifdef BRAM_STREAM_ABORT_EN
    start_burst(6'd0, 7'd10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #2;
      if (beats >= 3) break;
    end
    chk("abort_pre_beats", beats, 3);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #2;
    chk("abort_valid_drop", m_valid, 0);
    chk("abort_done", done, 1);
    repeat (3) @(negedge clk);
    #2;
    mon_on = 0;
    chk("abort_done_pulses", done_cnt, 1);
    chk("abort_no_last", last_cnt, 0);
    chk("abort_idle", busy, 0);
    chk("abort_buffered_le2", max_buf <= 2, 1);
    run_vec('{base: 6'd40, len: 7'd2, pat: 0, exp_done: 5, exp_first: 3});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Sequencer directly downstream of the dual-port BRAM's read port. It drives the BRAM's Port B, a read enable plus address with 1-cycle registered-output latency. It repackages the returned words as a valid/ready stream with a last-beat marker for the accelerator datapath (MAC array / FSM consumer). It hides BRAM latency, honours downstream backpressure without losing words, and sustains one word per cycle when the consumer is always ready.

## Interface
- DATA_WIDTH, 8, word width; must match the BRAM.
- ADDR_WIDTH, 6, BRAM address width (2^ADDR_WIDTH locations).

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  begin a burst; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first BRAM address of the burst; latched on accepted start.
- length  input  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH; latched on accepted start.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at burst completion.
- b_en  output  1  BRAM Port B read enable.
- b_addr  output  ADDR_WIDTH  BRAM Port B address.
- b_dout  input  DATA_WIDTH  BRAM Port B data, valid one cycle after b_en.
- m_valid  output  1  output word valid.
- m_ready  input  1  consumer accepts the word.
- m_data  output  DATA_WIDTH  output word.
- m_last  output  1  marks the final word of the burst; qualified by m_valid.

## Operation
- States:
  - IDLE.
  - RUN: issuing reads.
  - DRAIN: all reads issued, waiting for the buffer and in-flight read to empty.
  - DONE: done=1 for one cycle, then IDLE.
- Start handling:
  - IDLE and start=1 with length>0 goes to RUN; with length=0 goes straight to DONE, with no b_en.
  - start is ignored when not IDLE.
- Read issue:
  - In RUN, b_en=1 iff (fifo_count + inflight − pop) < 2, where pop = m_valid & m_ready in the same cycle.
  - b_addr = (base_addr + issued) mod 2^ADDR_WIDTH, so addresses wrap past the top.
  - RUN goes to DRAIN on the cycle issuing the final read.
- Capture: an `inflight` flag is set by b_en and cleared next cycle. When it is set, b_dout is pushed into the 2-entry output FIFO. Capacity accounting guarantees no overflow.
- Output:
  - m_data/m_valid come from the FIFO head.
  - m_last=1 on the beat whose index equals length−1.
- Completion: DRAIN goes to DONE when the FIFO is empty and inflight=0.
- Backpressure: with m_ready low indefinitely, at most 2 reads are outstanding-or-buffered. No word is dropped, duplicated or reordered.
- Arithmetic: the issued and delivered counters are ADDR_WIDTH+1 bits. length=2^ADDR_WIDTH reads every location exactly once.
- Reset values: busy=0, done=0, b_en=0, b_addr=0, m_valid=0, m_data=0, m_last=0. FIFO is empty, inflight=0, state is IDLE.
- Reset mid-burst: everything returns to the reset values immediately (asynchronously). No done pulse. Stale b_dout on the next cycle is ignored.

## Timing
- Start accepted at edge E0: b_en is high in the cycle after E0. The word is pushed at E2, and m_valid is high after E2 (first-word latency 2 cycles).
- With m_ready tied high: one word per cycle. The final handshake at edge Ek gives done=1 in the cycle after Ek.
- length=0: done=1 in the cycle after E0, IDLE after E1.
- done and the next accepted start can never coincide, because start is only accepted in IDLE.

## Configuration
- BRAM_STREAM_ABORT_EN defined:
  - Adds input `abort` (1 bit).
  - In RUN or DRAIN, abort=1 stops issue, flushes the FIFO, discards any in-flight word, and goes to DONE. done pulses once. No m_last is emitted for a truncated burst.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port. Every burst runs to completion.

## Structure
- Package bram_stream_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - FIFO depth constant (2).
  - localparam helper for counter width (ADDR_WIDTH+1).
- Sub-module stream_fifo2: 2-entry data+last FIFO with push/pop and a count output. It is reusable by other datapath stages.

## Test plan
- Preload addr i = i+16. start, base=4, length=5, m_ready=1 → data 20..24 on consecutive cycles, m_last on 24, done the cycle after.
- base=62, length=4 → b_addr sequence 62,63,0,1; data from those locations in order.
- length=5, m_ready toggled 1,0,0,1,0,1… → exactly 5 beats in address order, never more than 2 buffered, no repeats.
- length=0 → done pulse one cycle after start, b_en never asserted, m_valid stays 0.
- rst_n low for one cycle mid-burst (after 2 beats) → all outputs 0 immediately, no done. A new burst then completes correctly.
- With BRAM_STREAM_ABORT_EN: abort during RUN of length 10 → m_valid drops the next cycle, a single done pulse, no m_last, then IDLE.
